// File: rtl/sys_bus_pkg.sv
// Shared definitions for the serial system bus: arbiter FSM encoding, response codes
// used by slave/master interfaces, and the supported master count.
package sys_bus_pkg;

  localparam int MAX_MASTERS = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_BUSY    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational winner selection: round-robin starting after the base pointer,
// or fixed priority with index 0 highest when rr_en is low.
module arb_rr_picker
  import sys_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDW         = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDW-1:0]         base,
  input  logic                   rr_en,
  output logic                   valid,
  output logic [IDW-1:0]         winner
);

  logic           found;
  logic [IDW-1:0] idx;

  assign valid = |req;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    if (rr_en) begin
      // Scan ptr+1 .. ptr+N so the last winner is considered last.
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        idx = IDW'((32'(base) + 32'(k)) % 32'(NUM_MASTERS));
        if (!found && req[idx]) begin
          winner = idx;
          found  = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        idx = IDW'(k);
        if (req[idx]) begin
          winner = idx;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Serial system bus arbiter: one-hot grant, util watchdog, and a one-cycle
// turnaround gap before the bus can be handed to the next owner.
module bus_arbiter
  import sys_bus_pkg::*;
#(
  parameter int NUM_MASTERS   = 2,
  parameter int RR_EN         = 1,
  parameter int GRANT_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         bus_req,
  input  logic [NUM_MASTERS-1:0]         util,
  output logic [NUM_MASTERS-1:0]         grant,
  output logic [$clog2(NUM_MASTERS)-1:0] bus_owner,
  output logic                           bus_busy,
  output logic                           timeout_err,
  output logic                           protocol_err
);

  localparam int IDW = $clog2(NUM_MASTERS);
  localparam int TMW = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT_BASE = NUM_MASTERS'(1);

  logic [1:0]             state_reg;
  logic [TMW-1:0]         wait_cnt_reg;
  logic [IDW-1:0]         rr_ptr_reg;
  logic                   pick_valid;
  logic [IDW-1:0]         pick_winner;
  logic [NUM_MASTERS-1:0] stray_util;

  arb_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDW        (IDW)
  ) u_picker (
    .req   (bus_req),
    .base  (rr_ptr_reg),
    .rr_en (RR_EN != 0),
    .valid (pick_valid),
    .winner(pick_winner)
  );

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_stray
    assign stray_util[gi] = util[gi] & ~grant[gi];
  end

  assign bus_busy = (state_reg == ST_GRANT) || (state_reg == ST_BUSY);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      grant        <= '0;
      bus_owner    <= '0;
      wait_cnt_reg <= '0;
      rr_ptr_reg   <= IDW'(NUM_MASTERS - 1);
      timeout_err  <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      timeout_err  <= 1'b0;
      // The previous owner may still drive util during the turnaround cycle.
      protocol_err <= (state_reg != ST_RELEASE) && (|stray_util);
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            grant        <= ONE_HOT_BASE << pick_winner;
            bus_owner    <= pick_winner;
            wait_cnt_reg <= '0;
            state_reg    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (util[bus_owner]) begin
            rr_ptr_reg <= bus_owner;
            state_reg  <= ST_BUSY;
          end else if (!bus_req[bus_owner]) begin
            grant     <= '0;
            state_reg <= ST_IDLE;
          end else if (wait_cnt_reg == TMW'(GRANT_TIMEOUT - 1)) begin
            grant       <= '0;
            timeout_err <= 1'b1;
            rr_ptr_reg  <= bus_owner;
            state_reg   <= ST_IDLE;
          end else if (wait_cnt_reg != TMW'(GRANT_TIMEOUT)) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        ST_BUSY: begin
          if (!util[bus_owner]) begin
            grant     <= '0;
            state_reg <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a round-robin instance and a fixed-priority
// instance share the same stimulus; each test task checks the relevant one.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] bus_req;
  logic [1:0] util;
  logic [1:0] grant;
  logic       bus_owner;
  logic       bus_busy;
  logic       timeout_err;
  logic       protocol_err;
  logic [1:0] fp_grant;
  logic       fp_owner;
  logic       fp_busy;
  logic       fp_tout;
  logic       fp_perr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(2), .RR_EN(1), .GRANT_TIMEOUT(16)) dut_rr (
    .clk(clk), .reset(reset), .bus_req(bus_req), .util(util),
    .grant(grant), .bus_owner(bus_owner), .bus_busy(bus_busy),
    .timeout_err(timeout_err), .protocol_err(protocol_err)
  );

  bus_arbiter #(.NUM_MASTERS(2), .RR_EN(0), .GRANT_TIMEOUT(16)) dut_fp (
    .clk(clk), .reset(reset), .bus_req(bus_req), .util(util),
    .grant(fp_grant), .bus_owner(fp_owner), .bus_busy(fp_busy),
    .timeout_err(fp_tout), .protocol_err(fp_perr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset   = 1'b0;
    bus_req = 2'b00;
    util    = 2'b00;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus_req = 2'($urandom);
      util    = 2'($urandom);
      tick();
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
      checks++; if (bus_owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b expected 0", bus_owner); end
      checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_busy); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tout: got %b expected 0", timeout_err); end
      checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", protocol_err); end
    end
    reset   = 1'b1;
    bus_req = 2'b00;
    util    = 2'b00;
    tick();
    checks++; if (grant !== 2'b00 || bus_busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got grant=%b busy=%b expected 00/0", grant, bus_busy); end
    $display("reset: outputs idle after release");
  endtask

  task automatic test_single();
    bus_req = 2'b01;
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", grant); end
    checks++; if (bus_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus_busy); end
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_hold_unused: got %b expected 01", grant); end
    util    = 2'b01;
    bus_req = 2'b00;
    for (int c = 3; c <= 10; c++) begin
      tick();
      checks++; if (grant !== 2'b01 || protocol_err !== 1'b0) begin errors++; $display("FAIL single_busy_hold: edge %0d got grant=%b perr=%b expected 01/0", c, grant, protocol_err); end
    end
    util = 2'b00;
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_release_grant: got %b expected 00", grant); end
    checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL single_release_busy: got %b expected 0", bus_busy); end
    checks++; if (bus_owner !== 1'b0) begin errors++; $display("FAIL single_owner: got %b expected 0", bus_owner); end
    tick();
    $display("single: master 0 transfer complete");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [3];
    logic       exp_o [3];
    exp_g = '{2'b01, 2'b10, 2'b01};
    exp_o = '{1'b0, 1'b1, 1'b0};
    apply_reset();
    bus_req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++; if (grant !== exp_g[t]) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", t, grant, exp_g[t]); end
      checks++; if (bus_owner !== exp_o[t]) begin errors++; $display("FAIL rr_owner[%0d]: got %b expected %b", t, bus_owner, exp_o[t]); end
      util = exp_g[t];
      repeat (3) tick();
      checks++; if (grant !== exp_g[t] || bus_busy !== 1'b1) begin errors++; $display("FAIL rr_hold[%0d]: got grant=%b busy=%b expected %b/1", t, grant, bus_busy, exp_g[t]); end
      util = 2'b00;
      tick();
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_gap1[%0d]: got %b expected 00", t, grant); end
      tick();
      checks++; if (grant !== 2'b00 || bus_owner !== exp_o[t]) begin errors++; $display("FAIL rr_gap2[%0d]: got grant=%b owner=%b expected 00/%b", t, grant, bus_owner, exp_o[t]); end
      $display("rr: transfer %0d owner=%0d", t, exp_o[t]);
    end
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    bus_req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++; if (fp_grant !== 2'b01 || fp_owner !== 1'b0) begin errors++; $display("FAIL fp_grant[%0d]: got grant=%b owner=%b expected 01/0", t, fp_grant, fp_owner); end
      util = 2'b01;
      repeat (4) tick();
      checks++; if (fp_busy !== 1'b1 || fp_perr !== 1'b0 || fp_tout !== 1'b0) begin errors++; $display("FAIL fp_busy[%0d]: got busy=%b perr=%b tout=%b expected 1/0/0", t, fp_busy, fp_perr, fp_tout); end
      util = 2'b00;
      tick();
      checks++; if (fp_grant !== 2'b00) begin errors++; $display("FAIL fp_gap1[%0d]: got %b expected 00", t, fp_grant); end
      tick();
      checks++; if (fp_grant !== 2'b00) begin errors++; $display("FAIL fp_gap2[%0d]: got %b expected 00", t, fp_grant); end
      $display("fp: transfer %0d owner=0", t);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    bus_req = 2'b01;
    tick();
    util    = 2'b01;
    bus_req = 2'b00;
    repeat (2) tick();
    util = 2'b00;
    repeat (2) tick();
    bus_req = 2'b10;
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tout_grant: got %b expected 10", grant); end
    for (int c = 1; c < 16; c++) begin
      tick();
      checks++; if (grant !== 2'b10 || timeout_err !== 1'b0) begin errors++; $display("FAIL tout_hold: cycle %0d got grant=%b tout=%b expected 10/0", c, grant, timeout_err); end
    end
    bus_req = 2'b11;
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tout_revoke: got %b expected 00", grant); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tout_pulse: got %b expected 1", timeout_err); end
    tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tout_pulse_end: got %b expected 0", timeout_err); end
    checks++; if (grant !== 2'b01 || bus_owner !== 1'b0) begin errors++; $display("FAIL tout_next: got grant=%b owner=%b expected 01/0", grant, bus_owner); end
    $display("timeout: master 1 revoked, master 0 next");
  endtask

  task automatic test_reset_busy();
    apply_reset();
    bus_req = 2'b10;
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rstbusy_grant: got %b expected 10", grant); end
    util    = 2'b10;
    bus_req = 2'b00;
    repeat (2) tick();
    checks++; if (bus_busy !== 1'b1 || bus_owner !== 1'b1) begin errors++; $display("FAIL rstbusy_busy: got busy=%b owner=%b expected 1/1", bus_busy, bus_owner); end
    reset = 1'b0;
    tick();
    checks++; if (grant !== 2'b00 || bus_busy !== 1'b0) begin errors++; $display("FAIL rstbusy_drop: got grant=%b busy=%b expected 00/0", grant, bus_busy); end
    checks++; if (bus_owner !== 1'b0) begin errors++; $display("FAIL rstbusy_owner: got %b expected 0", bus_owner); end
    reset = 1'b1;
    tick();
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL rstbusy_perr: got %b expected 1", protocol_err); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rstbusy_nogrant: got %b expected 00", grant); end
    util = 2'b00;
    tick();
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL rstbusy_perr_end: got %b expected 0", protocol_err); end
    $display("reset_busy: grant dropped, stray util flagged once");
  endtask

  initial begin
    reset   = 1'b0;
    bus_req = 2'b00;
    util    = 2'b00;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected below 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
